// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encoding and the default operand width.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per
// step, plus the sign fix-up and result selection used in the FIXUP cycle.
// acc holds the product upper half (multiply) or the partial remainder
// (divide); lo holds the multiplier/product lower half or dividend/quotient.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    input  logic [2:0]      funct3,
    input  logic            neg,
    output logic [XLEN-1:0] fix_value
);

    logic [XLEN:0]   acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;

    logic [XLEN:0]     add_sum, partial, div_trial, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   rem_fix;

    // One multiply or divide iteration, or operand load.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        acc_d     = acc_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        add_sum   = {1'b0, acc_q[XLEN-1:0]} + {1'b0, opnd_q};
        partial   = lo_q[0] ? add_sum : {1'b0, acc_q[XLEN-1:0]};
        div_trial = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, opnd_q};
        if (load) begin
            acc_d  = '0;
            lo_d   = a_mag;
            opnd_d = b_mag;
        end else if (step) begin
            if (funct3[2]) begin
                if (div_trial >= {1'b0, opnd_q}) begin
                    acc_d = div_diff;
                    lo_d  = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = div_trial;
                    lo_d  = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                // Carry of the add lands in partial[XLEN] and shifts down into the product.
                acc_d = {1'b0, partial[XLEN:1]};
                lo_d  = {partial[0], lo_q[XLEN-1:1]};
            end
        end
    end

    // Sign fix-up: the product is negated as a full 2*XLEN value so the high
    // half borrows correctly; the remainder is negated on its own.
    always_comb begin
        prod     = {acc_q[XLEN-1:0], lo_q};
        prod_fix = neg ? -prod : prod;
        rem_fix  = neg ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        case (funct3)
            F3_MUL, F3_DIV, F3_DIVU:    fix_value = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_value = prod_fix[2*XLEN-1:XLEN];
            default:                    fix_value = rem_fix;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too so simulation never propagates X after reset.
        if (reset) begin
            acc_q  <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: accepts an M-extension op, conditions the
// operands, runs the iterative datapath for XLEN cycles, fixes up the sign
// and holds busy until the one-cycle done pulse. Divide-by-zero and signed
// overflow bypass the datapath and complete on the next edge.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t state_q, state_d;

    logic [2:0]      funct3_q, funct3_d;
    logic            neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept, load, step, fixup;
    logic            signed_a, signed_b, sign_a, sign_b, neg_acc;
    logic [XLEN-1:0] a_mag, b_mag, special_value, fix_value;
    logic            div_zero, div_ovf, special;

    // Operand conditioning and special-case detection on the incoming request.
    always_comb begin
        signed_a = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        signed_b = funct3 inside {F3_MULH, F3_DIV, F3_REM};
        sign_a   = signed_a & op_a[XLEN-1];
        sign_b   = signed_b & op_b[XLEN-1];
        a_mag    = sign_a ? -op_a : op_a;
        b_mag    = sign_b ? -op_b : op_b;
        neg_acc  = (funct3 == F3_REM) ? sign_a : (sign_a ^ sign_b);
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = (funct3 == F3_DIV || funct3 == F3_REM)
                   && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_value = funct3[1] ? op_a : '1;
        end else begin
            special_value = funct3[1] ? '0 : op_a;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; kill aborts from any state.
    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = special ? DONE : CALC;
                CALC:    if (cnt_q == '0) state_d = FIXUP;
                FIXUP:   state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs and datapath strobes.
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        accept = (state_q == IDLE) && start && !kill;
        load   = accept && !special;
        step   = (state_q == CALC);
        fixup  = (state_q == FIXUP) && !kill;
    end

    // Latched op, sign flag, iteration counter and result.
    always_comb begin
        funct3_d = funct3_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (accept) begin
            funct3_d = funct3;
            neg_d    = neg_acc;
            if (special) begin
                result_d = special_value;
            end else begin
                cnt_d = CNT_W'(XLEN - 1);
            end
        end else if (step && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (fixup) begin
            result_d = fix_value;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            funct3_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .funct3    (funct3_q),
        .neg       (neg_q),
        .fix_value (fix_value)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a table of ops with hand-computed
// results and done latencies, plus sequences for kill, reset, and start
// while busy / back-to-back starts.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;
    localparam int MAXC = 60;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            kill = 1'b0;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int n_vec  = 0;
    int n_miss = 0;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          cyc;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle (cycle 0) and stop in the done cycle.
    // Operand inputs are scrambled after accept to prove they were latched.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int done_cyc, output bit busy_ok);
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        funct3 = ~f3;
        op_a   = ~a;
        op_b   = ~b;
        done_cyc = -1;
        busy_ok  = 1'b1;
        res      = result;
        for (int c = 1; c <= MAXC; c++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                done_cyc = c;
                res      = result;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic [31:0] res;
        int          dc;
        bit          bok;
        bit          seen;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[2]  = '{3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 34};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,        32'd14,       34};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,        32'd2,        34};
        vecs[8]  = '{3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,          32'd0,        32'd5,        1};
        vecs[10] = '{3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
        vecs[11] = '{3'b111, 32'd5,          32'd0,        32'd5,        1};
        vecs[12] = '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        vecs[13] = '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
        vecs[14] = '{3'b000, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        34};
        vecs[15] = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0,        34};
        vecs[16] = '{3'b100, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        vecs[17] = '{3'b110, 32'd7,          32'hFFFFFFFE, 32'd1,        34};
        vecs[18] = '{3'b101, 32'h80000000,   32'hFFFFFFFF, 32'd0,        34};
        vecs[19] = '{3'b111, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 34};
        vecs[20] = '{3'b010, 32'h80000000,   32'd2,        32'hFFFFFFFF, 34};
        vecs[21] = '{3'b001, 32'h80000000,   32'd1,        32'hFFFFFFFF, 34};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;
        tick();

        // Table: each op issued in the cycle after the previous done.
        foreach (vecs[i]) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, dc, bok);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d done cycle", i), dc, vecs[i].cyc);
            check($sformatf("vec%0d busy held", i), {31'd0, bok}, 32'd1);
            tick();
            check($sformatf("vec%0d idle after done", i), {30'd0, busy, done}, 32'd0);
        end

        // Known result ahead of the kill test.
        run_op(3'b000, 32'd6, 32'd7, res, dc, bok);
        check("mul 6*7", res, 32'd42);
        tick();

        // kill in cycle 10 of a MUL: idle in cycle 11, no done, result kept.
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("kill busy before", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill busy after", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        check("kill no done", {31'd0, seen}, 32'd0);
        check("kill result kept", result, 32'd42);

        // start+kill together from IDLE: dropped.
        funct3 = 3'b101; op_a = 32'd9; op_b = 32'd3; start = 1'b1; kill = 1'b1;
        tick();
        start = 1'b0; kill = 1'b0;
        check("start+kill not accepted", {31'd0, busy}, 32'd0);
        tick();
        check("start+kill still idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a DIV.
        funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset result", result, 32'd0);
        reset = 1'b0;
        tick();

        // Start pulsed while busy, and again during DONE: both ignored.
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        dc = -1;
        res = '0;
        for (int c = 1; c <= MAXC; c++) begin
            if (c == 5) begin
                funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
            end else if (c == 6) begin
                start = 1'b0;
            end
            if (done) begin
                dc  = c;
                res = result;
                break;
            end
            tick();
        end
        check("busy-start done cycle", dc, 32'd34);
        check("busy-start result", res, 32'd14);
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
        tick();
        check("start in DONE ignored", {31'd0, busy}, 32'd0);
        check("start in DONE result kept", result, 32'd14);

        // Back-to-back: start held into the cycle after done is accepted.
        run_op(3'b000, 32'd3, 32'd3, res, dc, bok);
        check("back-to-back result", res, 32'd9);
        check("back-to-back done cycle", dc, 32'd34);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
